// File: rtl/seg7_bcd_counter_display.sv
// DIGITS-wide BCD counter with debounced button and switch-selected mode.
// The count drives one registered seven-segment decoder per digit.
module seg7_bcd_counter_display #(
    parameter int unsigned DIGITS          = 6,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned TICK_DIV        = 50000000,
    parameter bit          SEG_ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset,
    input  logic                  button_external_connection_export,
    input  logic [1:0]            switchs_external_connection_export,
    output logic [7*DIGITS-1:0]   segments_export,
    output logic                  wrap_pulse
);
    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned TICK_W = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_UP     = 2'b01,
        MODE_DOWN   = 2'b10,
        MODE_MANUAL = 2'b11
    } mode_e;

    logic                      btn_s1_q, btn_s2_q;
    logic [1:0]                sw_s1_q, sw_s2_q, mode_prev_q;
    logic [DB_W-1:0]           db_cnt_q, db_cnt_d;
    logic                      db_level_q, db_level_d;
    logic                      press_q, press_d;
    logic [TICK_W-1:0]         presc_q, presc_d;
    logic [DIGITS-1:0][3:0]    count_q, count_d;
    logic                      wrap_q, wrap_d;
    logic [7*DIGITS-1:0]       seg_q, seg_d;

    mode_e                     mode;
    logic                      run, mode_chg, tick;
    logic [DIGITS-1:0][3:0]    inc_val, dec_val;
    logic                      inc_carry, dec_borrow;

    assign mode     = mode_e'(sw_s2_q);
    assign mode_chg = (sw_s2_q != mode_prev_q);
    assign run      = (mode == MODE_UP) || (mode == MODE_DOWN);
    assign tick     = run && !mode_chg && (presc_q == TICK_W'(TICK_DIV - 1));

    always_comb begin
        db_cnt_d   = db_cnt_q;
        db_level_d = db_level_q;
        press_d    = 1'b0;
        if (btn_s2_q == db_level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            db_level_d = btn_s2_q;
            db_cnt_d   = '0;
            press_d    = ~btn_s2_q;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

    always_comb begin
        if (!run || mode_chg || tick) presc_d = '0;
        else                          presc_d = presc_q + TICK_W'(1);
    end

    // Carry/borrow ripple across all digits in one cycle; the final carry is the wrap.
    always_comb begin
        inc_val    = count_q;
        dec_val    = count_q;
        inc_carry  = 1'b1;
        dec_borrow = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (inc_carry) begin
                if (count_q[i] == 4'd9) inc_val[i] = 4'd0;
                else begin
                    inc_val[i] = count_q[i] + 4'd1;
                    inc_carry  = 1'b0;
                end
            end
            if (dec_borrow) begin
                if (count_q[i] == 4'd0) dec_val[i] = 4'd9;
                else begin
                    dec_val[i] = count_q[i] - 4'd1;
                    dec_borrow = 1'b0;
                end
            end
        end
    end

    // A press takes priority over a coincident tick, which is simply dropped.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (press_q) begin
            if (mode == MODE_MANUAL) begin
                count_d = inc_val;
                wrap_d  = inc_carry;
            end else begin
                count_d = '0;
            end
        end else if (tick) begin
            if (mode == MODE_UP) begin
                count_d = inc_val;
                wrap_d  = inc_carry;
            end else begin
                count_d = dec_val;
                wrap_d  = dec_borrow;
            end
        end
    end

    always_comb begin
        seg_d = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            logic [6:0] code;
            case (count_q[i])
                4'd0:    code = 7'b0111111;
                4'd1:    code = 7'b0000110;
                4'd2:    code = 7'b1011011;
                4'd3:    code = 7'b1001111;
                4'd4:    code = 7'b1100110;
                4'd5:    code = 7'b1101101;
                4'd6:    code = 7'b1111101;
                4'd7:    code = 7'b0000111;
                4'd8:    code = 7'b1111111;
                4'd9:    code = 7'b1101111;
                default: code = 7'b0000000;
            endcase
            seg_d[7*i +: 7] = SEG_ACTIVE_LOW ? ~code : code;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            btn_s1_q    <= 1'b1;
            btn_s2_q    <= 1'b1;
            sw_s1_q     <= '0;
            sw_s2_q     <= '0;
            mode_prev_q <= '0;
            db_cnt_q    <= '0;
            db_level_q  <= 1'b1;
            press_q     <= 1'b0;
            presc_q     <= '0;
            count_q     <= '0;
            wrap_q      <= 1'b0;
            for (int unsigned i = 0; i < DIGITS; i++)
                seg_q[7*i +: 7] <= SEG_ACTIVE_LOW ? 7'b1000000 : 7'b0111111;
        end else begin
            btn_s1_q    <= button_external_connection_export;
            btn_s2_q    <= btn_s1_q;
            sw_s1_q     <= switchs_external_connection_export;
            sw_s2_q     <= sw_s1_q;
            mode_prev_q <= sw_s2_q;
            db_cnt_q    <= db_cnt_d;
            db_level_q  <= db_level_d;
            press_q     <= press_d;
            presc_q     <= presc_d;
            count_q     <= count_d;
            wrap_q      <= wrap_d;
            seg_q       <= seg_d;
        end
    end

    assign segments_export = seg_q;
    assign wrap_pulse      = wrap_q;
endmodule

// File: tb/tb_seg7_bcd_counter_display.sv
// Directed bench for a 2-digit instance with short debounce and tick periods.
module tb_seg7_bcd_counter_display;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn = 1'b1;
    logic [1:0]  sw  = 2'b00;
    logic [13:0] seg;
    logic        wrap;
    int          errors = 0;
    int          checks = 0;

    seg7_bcd_counter_display #(
        .DIGITS(2),
        .DEBOUNCE_CYCLES(4),
        .TICK_DIV(3),
        .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk_clk(clk),
        .reset_reset(rst),
        .button_external_connection_export(btn),
        .switchs_external_connection_export(sw),
        .segments_export(seg),
        .wrap_pulse(wrap)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_hi(input int d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            default: return 7'b1101111;
        endcase
    endfunction

    function automatic logic [13:0] enc(input int n);
        return ~{seg_hi(n / 10), seg_hi(n % 10)};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [13:0] obs, input logic [13:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Holds reset for three edges; afterwards the bench sits just after edge 0.
    task automatic do_reset(input logic [1:0] mode, input logic b);
        rst = 1'b1;
        sw  = mode;
        btn = b;
        step(3);
        rst = 1'b0;
    endtask

    initial begin
        // Auto-up: count n lands on edge 3+3n, display one edge later.
        do_reset(2'b01, 1'b1);
        check("reset_seg", seg, 14'b1000000_1000000);
        check("reset_wrap", {13'b0, wrap}, 14'd0);
        step(4);
        check("up_start_seg", seg, enc(0));
        for (int n = 1; n <= 100; n++) begin
            step(2);
            check($sformatf("up_wrap_%0d", n), {13'b0, wrap}, {13'b0, n == 100});
            step(1);
            check($sformatf("up_seg_%0d", n), seg, enc(n % 100));
            check($sformatf("up_wrap_low_%0d", n), {13'b0, wrap}, 14'd0);
        end

        // Auto-down: first tick wraps 00 -> 99, second gives 98.
        do_reset(2'b10, 1'b1);
        step(6);
        check("down_wrap_99", {13'b0, wrap}, 14'd1);
        step(1);
        check("down_seg_99", seg, enc(99));
        check("down_wrap_low", {13'b0, wrap}, 14'd0);
        step(2);
        check("down_wrap_98", {13'b0, wrap}, 14'd0);
        step(1);
        check("down_seg_98", seg, enc(98));

        // Manual: 3-cycle bounces are rejected, a long hold counts once.
        do_reset(2'b11, 1'b1);
        step(5);
        for (int k = 0; k < 3; k++) begin
            btn = 1'b0;
            step(3);
            btn = 1'b1;
            step(3);
        end
        step(4);
        check("bounce_no_count", seg, enc(0));
        btn = 1'b0;
        step(7);
        check("press_latency_before", seg, enc(0));
        step(1);
        check("press_seg_01", seg, 14'b1000000_1111001);
        step(12);
        check("hold_single_pulse", seg, enc(1));
        btn = 1'b1;
        step(10);
        check("release_no_pulse", seg, enc(1));

        // Auto-up: press pulse lands on the tick cycle at count 05.
        do_reset(2'b01, 1'b1);
        step(14);
        btn = 1'b0;
        step(6);
        check("coinc_seg_05", seg, enc(5));
        step(1);
        check("coinc_no_wrap", {13'b0, wrap}, 14'd0);
        step(1);
        check("coinc_clear", seg, enc(0));
        btn = 1'b1;
        step(3);
        check("coinc_resume", seg, enc(1));

        // Mode 01 -> 00 -> 01 with the prescaler one cycle from a tick.
        do_reset(2'b01, 1'b1);
        step(6);
        sw = 2'b00;
        step(2);
        sw = 2'b01;
        step(6);
        check("restart_no_early_tick", seg, enc(1));
        step(1);
        check("restart_tick", seg, enc(2));

        // Reset at count 47 while a debounce is in progress.
        do_reset(2'b01, 1'b1);
        step(141);
        btn = 1'b0;
        step(3);
        check("pre_reset_seg_46", seg, enc(46));
        rst = 1'b1;
        btn = 1'b1;
        sw  = 2'b11;
        step(1);
        rst = 1'b0;
        check("mid_reset_seg", seg, enc(0));
        check("mid_reset_wrap", {13'b0, wrap}, 14'd0);
        step(15);
        check("post_reset_no_press", seg, enc(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seg7_bcd_counter_display.md
# seg7_bcd_counter_display

Parametrised successor to the fixed six-display button/switch platform. It is a DIGITS-wide BCD counter driven either by a prescaled auto tick or by debounced button presses, with the mode chosen by two switches. The block drives DIGITS seven-segment displays directly from registered decoders. It sits between the board pins (button, switches, displays) and replaces the per-display PIO peripherals.

## Interface
- DIGITS, 6, number of BCD digits and displays (1..8)
- DEBOUNCE_CYCLES, 500000, consecutive stable synchronized cycles required to accept a button level change (≥2)
- TICK_DIV, 50000000, clock cycles per auto-count tick (≥2)
- SEG_ACTIVE_LOW, 1, 1 = segment lit on 0 (board default), 0 = lit on 1
- clk_clk  in  1  single clock for all logic
- reset_reset  in  1  synchronous, active-high reset
- button_external_connection_export  in  1  raw button, active-low (0 = pressed), asynchronous
- switchs_external_connection_export  in  2  raw mode switches, asynchronous
- segments_export  out  7*DIGITS  digit i on bits [7i+6:7i], bit order g..a (bit 6 = g, bit 0 = a); digit 0 is least significant
- wrap_pulse  out  1  one-cycle pulse on counter wrap in either direction

## Operation
- Inputs: button and both switches each pass through a 2-flop synchronizer (reset value 1 for button, 0 for switches).
- Debounce:
  - A counter clears whenever the synchronized button differs from the debounced level.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the input still different, the debounced level takes the new value and the counter clears.
  - A 1→0 transition of the debounced level produces a one-cycle press pulse. Release produces no pulse.
- Mode, from synchronized switches:
  - 00 hold: count frozen; press clears count to 0.
  - 01 auto up: each tick adds 1; press clears to 0.
  - 10 auto down: each tick subtracts 1; press clears to 0.
  - 11 manual: each press adds 1; ticks ignored.
- Prescaler: counts 0..TICK_DIV-1 and emits a tick on the TICK_DIV-1 cycle, then returns to 0.
  - It runs only in modes 01 and 10.
  - It is held at 0 in modes 00 and 11.
  - It is forced to 0 in any cycle where the synchronized mode differs from its previous-cycle value.
- BCD arithmetic: each digit stays in 0..9.
  - Up: carry ripples through digits within one cycle; all-9s → all-0s asserts wrap_pulse.
  - Down: borrow ripples; all-0s → all-9s asserts wrap_pulse.
  - Clear never asserts wrap_pulse.
- Decoder: registered, per digit. Active-high codes (g..a): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111. The output is inverted when SEG_ACTIVE_LOW=1.
- Simultaneous events: press and tick in the same cycle → the press action wins (clear in 00/01/10), and the tick is discarded.

## Timing
- Reset (synchronous, active-high): count=0, prescaler=0, debounce counter=0, debounced level=1 (released), press pulse=0, wrap_pulse=0, every digit of segments_export shows '0' (1000000 per digit with SEG_ACTIVE_LOW=1).
- Reset asserted mid-debounce or mid-count returns all state to reset values on the next edge. Reset overrides press and tick.
- Button latency: a pin change held stable appears on the synchronizer output after 2 edges. The press pulse is asserted DEBOUNCE_CYCLES edges later.
- Count changes on the edge after the press pulse or tick. wrap_pulse is asserted in that same cycle as the count change.
- segments_export updates one edge after the count changes.
- Bounce shorter than DEBOUNCE_CYCLES stable cycles produces no pulse.
- A press held indefinitely produces exactly one pulse.
- Switch changes take effect 2 edges after the pin change (no debounce).

## Test plan
- DIGITS=2, TICK_DIV=3, mode 01 from reset → count 00,01,02… every 3 cycles; at 99→00 wrap_pulse is high for exactly 1 cycle; displays read '0','0' afterwards.
- Mode 10 from reset → first tick gives 99 with wrap_pulse=1; the next tick gives 98.
- DEBOUNCE_CYCLES=4, mode 11: button low for 3 cycles then high, repeated (bounce) → no count change. Button then held low for 10 cycles → count increments by exactly 1, and segments for digit 0 show '1' (1111001 active-low).
- Mode 01: press pulse coincident with tick at count 05 → count becomes 00, no wrap_pulse.
- Mode switched 01→00→01 mid-prescale → prescaler restarts; the next tick arrives TICK_DIV cycles after the mode change is synchronized.
- Assert reset_reset for 1 cycle at count 47 during an active debounce → count 00, all displays '0', no press pulse after reset releases while the button remains high.
